// File: rtl/cpu64_l1_arrays_v2.sv
// L1 data/tag/state arrays with registered parallel-way reads, write-first bypass and invalidate walker.
// Optional per-byte even parity storage and checking enabled by defining L1_ARRAYS_PARITY_EN.
module cpu64_l1_arrays_v2 #(
  parameter int unsigned SETS       = 32,
  parameter int unsigned WAYS       = 8,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned TAG_W      = 53,
  parameter int unsigned INDEX_W    = $clog2(SETS),
  parameter int unsigned WORD_W     = $clog2(LINE_WORDS),
  parameter int unsigned WAY_W      = $clog2(WAYS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rd_req_i,
  input  logic [INDEX_W-1:0]       rd_index_i,
  input  logic [WORD_W-1:0]        rd_word_i,
  output logic                     rd_valid_o,
  output logic [WAYS*DATA_W-1:0]   rd_data_way_o,
  output logic [WAYS*TAG_W-1:0]    rd_tag_way_o,
  output logic [WAYS*2-1:0]        rd_state_way_o,
  output logic [WAYS-1:0]          rd_perr_way_o,
  input  logic                     wr_en_i,
  input  logic [WAY_W-1:0]         wr_way_i,
  input  logic [INDEX_W-1:0]       wr_index_i,
  input  logic [WORD_W-1:0]        wr_word_i,
  input  logic [DATA_W/8-1:0]      wr_be_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     meta_we_i,
  input  logic [WAY_W-1:0]         meta_way_i,
  input  logic [INDEX_W-1:0]       meta_index_i,
  input  logic [TAG_W-1:0]         meta_tag_i,
  input  logic [1:0]               meta_state_i,
  input  logic                     inv_all_i,
  output logic                     busy_o,
  output logic                     inv_done_o
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned DEPTH   = SETS * WAYS * LINE_WORDS;
  localparam int unsigned ENTRIES = SETS * WAYS;
  localparam int unsigned DADDR_W = INDEX_W + WAY_W + WORD_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

  logic [DATA_W-1:0]          r_data_mem [DEPTH];
  logic [TAG_W-1:0]           r_tag_mem  [ENTRIES];
  logic [ENTRIES-1:0][1:0]    r_state;

  logic [1:0]                 r_fsm, w_fsm_nxt;
  logic [INDEX_W-1:0]         r_cnt, w_cnt_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;

  logic                       r_rd_valid;
  logic [WAYS*DATA_W-1:0]     r_rd_data, w_rd_data;
  logic [WAYS*TAG_W-1:0]      r_rd_tag, w_rd_tag;
  logic [WAYS*2-1:0]          r_rd_state, w_rd_state;

  logic                       w_wr_fire, w_meta_fire, w_rd_fire;
  logic [DADDR_W-1:0]         w_waddr;
  logic [DATA_W-1:0]          w_raw, w_word;
  logic                       w_dhit;

  // Everything except the walker is frozen while the walk is in progress.
  assign w_wr_fire   = wr_en_i   & ~r_busy;
  assign w_meta_fire = meta_we_i & ~r_busy;
  assign w_rd_fire   = rd_req_i  & ~r_busy;
  assign w_waddr     = {wr_index_i, wr_way_i, wr_word_i};

  // Walker state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm  <= ST_IDLE;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Walker next state; busy/done are registered copies of the next state.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    case (r_fsm)
      ST_IDLE: begin
        if (inv_all_i) begin
          w_fsm_nxt = ST_WALK;
          w_cnt_nxt = '0;
        end
      end
      ST_WALK: begin
        if (r_cnt == LAST_SET) w_fsm_nxt = ST_DONE;
        else                   w_cnt_nxt = r_cnt + INDEX_W'(1);
      end
      ST_DONE: w_fsm_nxt = ST_IDLE;
      default: w_fsm_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_fsm_nxt == ST_WALK);
    w_done_nxt = (w_fsm_nxt == ST_DONE);
  end

  // Byte-masked data word write.
  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_be_i[b]) r_data_mem[w_waddr][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_meta_fire) r_tag_mem[{meta_index_i, meta_way_i}] <= meta_tag_i;
  end

  // State is the only array that resets; the walker clears one set per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= '0;
    end else if (r_fsm == ST_WALK) begin
      for (int unsigned w = 0; w < WAYS; w++) r_state[{r_cnt, WAY_W'(w)}] <= 2'b00;
    end else if (w_meta_fire) begin
      r_state[{meta_index_i, meta_way_i}] <= meta_state_i;
    end
  end

`ifdef L1_ARRAYS_PARITY_EN
  logic [BYTES-1:0] r_par_mem [DEPTH];
  logic [WAYS-1:0]  r_rd_perr, w_rd_perr;

  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_be_i[b]) r_par_mem[w_waddr][b] <= ^wr_data_i[b*8 +: 8];
      end
    end
  end
`endif

  // Per-way read mux with write-first bypass of same-cycle data/meta writes.
  always_comb begin
    w_rd_data  = '0;
    w_rd_tag   = '0;
    w_rd_state = '0;
    w_raw      = '0;
    w_word     = '0;
    w_dhit     = 1'b0;
`ifdef L1_ARRAYS_PARITY_EN
    w_rd_perr  = '0;
`endif
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_raw  = r_data_mem[{rd_index_i, WAY_W'(w), rd_word_i}];
      w_word = w_raw;
      w_dhit = w_wr_fire && (wr_index_i == rd_index_i) && (wr_word_i == rd_word_i) &&
               (wr_way_i == WAY_W'(w));
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_dhit && wr_be_i[b]) w_word[b*8 +: 8] = wr_data_i[b*8 +: 8];
      end
      w_rd_data[w*DATA_W +: DATA_W] = w_word;
      if (w_meta_fire && (meta_index_i == rd_index_i) && (meta_way_i == WAY_W'(w))) begin
        w_rd_tag[w*TAG_W +: TAG_W] = meta_tag_i;
        w_rd_state[w*2 +: 2]       = meta_state_i;
      end else begin
        w_rd_tag[w*TAG_W +: TAG_W] = r_tag_mem[{rd_index_i, WAY_W'(w)}];
        w_rd_state[w*2 +: 2]       = r_state[{rd_index_i, WAY_W'(w)}];
      end
`ifdef L1_ARRAYS_PARITY_EN
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (r_par_mem[{rd_index_i, WAY_W'(w), rd_word_i}][b] != ^w_raw[b*8 +: 8]) w_rd_perr[w] = 1'b1;
      end
      if (w_dhit) w_rd_perr[w] = 1'b0;
`endif
    end
  end

  // Read output registers hold between accepted reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_tag   <= '0;
      r_rd_state <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data  <= w_rd_data;
        r_rd_tag   <= w_rd_tag;
        r_rd_state <= w_rd_state;
      end
    end
  end

`ifdef L1_ARRAYS_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_rd_perr <= '0;
    else if (w_rd_fire) r_rd_perr <= w_rd_perr;
  end
  assign rd_perr_way_o = r_rd_perr;
`else
  assign rd_perr_way_o = '0;
`endif

  assign rd_valid_o     = r_rd_valid;
  assign rd_data_way_o  = r_rd_data;
  assign rd_tag_way_o   = r_rd_tag;
  assign rd_state_way_o = r_rd_state;
  assign busy_o         = r_busy;
  assign inv_done_o     = r_done;

endmodule

// File: tb/tb_cpu64_l1_arrays_v2.sv
// Randomized bench for cpu64_l1_arrays_v2 against an array-level reference model.
module tb_cpu64_l1_arrays_v2;
  localparam int unsigned SETS = 32, WAYS = 8, LW = 8, DW = 64, TW = 53;
  localparam int unsigned IW = 5, KW = 3, WW = 3, BW = DW / 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic            rd_req_i, wr_en_i, meta_we_i, inv_all_i;
  logic [IW-1:0]   rd_index_i, wr_index_i, meta_index_i;
  logic [KW-1:0]   rd_word_i, wr_word_i;
  logic [WW-1:0]   wr_way_i, meta_way_i;
  logic [BW-1:0]   wr_be_i;
  logic [DW-1:0]   wr_data_i;
  logic [TW-1:0]   meta_tag_i;
  logic [1:0]      meta_state_i;
  logic            rd_valid_o, busy_o, inv_done_o;
  logic [WAYS*DW-1:0] rd_data_way_o;
  logic [WAYS*TW-1:0] rd_tag_way_o;
  logic [WAYS*2-1:0]  rd_state_way_o;
  logic [WAYS-1:0]    rd_perr_way_o;

  cpu64_l1_arrays_v2 dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_req_i(rd_req_i), .rd_index_i(rd_index_i), .rd_word_i(rd_word_i),
    .rd_valid_o(rd_valid_o), .rd_data_way_o(rd_data_way_o), .rd_tag_way_o(rd_tag_way_o),
    .rd_state_way_o(rd_state_way_o), .rd_perr_way_o(rd_perr_way_o),
    .wr_en_i(wr_en_i), .wr_way_i(wr_way_i), .wr_index_i(wr_index_i), .wr_word_i(wr_word_i),
    .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .meta_we_i(meta_we_i), .meta_way_i(meta_way_i), .meta_index_i(meta_index_i),
    .meta_tag_i(meta_tag_i), .meta_state_i(meta_state_i),
    .inv_all_i(inv_all_i), .busy_o(busy_o), .inv_done_o(inv_done_o)
  );

  // Reference model: plain arrays plus an abstract walk countdown.
  logic [DW-1:0] m_data  [SETS][WAYS][LW];
  logic [TW-1:0] m_tag   [SETS][WAYS];
  logic [1:0]    m_state [SETS][WAYS];
  int            m_left;
  logic          m_busy, m_done;
  logic          exp_valid;
  logic [WAYS*DW-1:0] exp_data;
  logic [WAYS*TW-1:0] exp_tag;
  logic [WAYS*2-1:0]  exp_state;
  logic [WAYS-1:0]    exp_perr;
  int total = 0, bad = 0;

  task automatic set_idle();
    rd_req_i = 0; wr_en_i = 0; meta_we_i = 0; inv_all_i = 0;
    rd_index_i = '0; rd_word_i = '0; wr_index_i = '0; wr_word_i = '0; wr_way_i = '0;
    wr_be_i = '0; wr_data_i = '0; meta_index_i = '0; meta_way_i = '0; meta_tag_i = '0;
    meta_state_i = '0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_state[s][w] = 2'd0;
    m_left = 0; m_busy = 0; m_done = 0; exp_valid = 0;
    exp_data = '0; exp_tag = '0; exp_state = '0; exp_perr = '0;
  endtask

  // Apply current inputs to the model (writes first, so reads see them), then advance one clock.
  task automatic cycle();
    logic rd_acc, inv_acc, new_done;
    rd_acc  = rd_req_i && !m_busy;
    inv_acc = inv_all_i && !m_busy && !m_done;
    if (!m_busy) begin
      if (wr_en_i)
        for (int b = 0; b < BW; b++)
          if (wr_be_i[b]) m_data[wr_index_i][wr_way_i][wr_word_i][b*8 +: 8] = wr_data_i[b*8 +: 8];
      if (meta_we_i) begin
        m_tag[meta_index_i][meta_way_i]   = meta_tag_i;
        m_state[meta_index_i][meta_way_i] = meta_state_i;
      end
    end
    if (rd_acc) begin
      for (int w = 0; w < WAYS; w++) begin
        exp_data[w*DW +: DW] = m_data[rd_index_i][w][rd_word_i];
        exp_tag[w*TW +: TW]  = m_tag[rd_index_i][w];
        exp_state[w*2 +: 2]  = m_state[rd_index_i][w];
      end
      exp_perr = '0;
    end
    new_done = 0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) new_done = 1;
    end
    if (inv_acc) begin
      m_left = SETS;
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_state[s][w] = 2'd0;
    end
    m_busy = (m_left > 0);
    m_done = new_done;
    exp_valid = rd_acc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || inv_done_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b want 000", rd_valid_o, busy_o, inv_done_o);
    end
    total++;
    if (rd_data_way_o !== '0 || rd_tag_way_o !== '0 || rd_state_way_o !== '0 || rd_perr_way_o !== '0) begin
      bad++; $display("FAIL reset_outs: outputs not zero data=%h tag=%h", rd_data_way_o, rd_tag_way_o);
    end
    set_idle(); rd_req_i = 1; rd_index_i = 5; rd_word_i = 0;
    cycle(); set_idle();
    total++;
    if (rd_valid_o !== 1'b1) begin bad++; $display("FAIL reset_read_valid: got %b want 1", rd_valid_o); end
    total++;
    if (rd_state_way_o !== '0) begin bad++; $display("FAIL reset_read_state: got %h want 0", rd_state_way_o); end
  endtask

  // Give every stored word and tag a known random value.
  task automatic fill_arrays();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        for (int k = 0; k < LW; k++) begin
          set_idle();
          wr_en_i = 1; wr_index_i = IW'(s); wr_way_i = WW'(w); wr_word_i = KW'(k);
          wr_be_i = '1; wr_data_i = {$urandom, $urandom};
          if (k == 0) begin
            meta_we_i = 1; meta_index_i = IW'(s); meta_way_i = WW'(w);
            meta_tag_i = TW'({$urandom, $urandom}); meta_state_i = 2'd0;
          end
          cycle();
        end
    set_idle();
  endtask

  task automatic test_byte_write();
    set_idle(); meta_we_i = 1; meta_way_i = 3; meta_index_i = 7; meta_tag_i = TW'(16'h1ABC); meta_state_i = 2'd2;
    cycle();
    set_idle(); wr_en_i = 1; wr_way_i = 3; wr_index_i = 7; wr_word_i = 2; wr_be_i = 8'hFF; wr_data_i = '1;
    cycle();
    set_idle(); wr_en_i = 1; wr_way_i = 3; wr_index_i = 7; wr_word_i = 2; wr_be_i = 8'h0F;
    wr_data_i = 64'h1122334455667788;
    cycle();
    set_idle(); wr_en_i = 1; wr_way_i = 3; wr_index_i = 7; wr_word_i = 2; wr_be_i = 8'h00; wr_data_i = '0;
    cycle();
    set_idle(); rd_req_i = 1; rd_index_i = 7; rd_word_i = 2;
    cycle(); set_idle();
    total++;
    if (rd_data_way_o[3*DW +: DW] !== 64'hFFFFFFFF55667788) begin
      bad++; $display("FAIL byte_write_data: got %h want ffffffff55667788", rd_data_way_o[3*DW +: DW]);
    end
    total++;
    if (rd_tag_way_o[3*TW +: TW] !== TW'(16'h1ABC) || rd_state_way_o[7:6] !== 2'd2) begin
      bad++; $display("FAIL byte_write_meta: tag=%h state=%0d want 1abc/2", rd_tag_way_o[3*TW +: TW], rd_state_way_o[7:6]);
    end
    total++;
    if (rd_data_way_o !== exp_data || rd_tag_way_o !== exp_tag) begin
      bad++; $display("FAIL byte_write_others: data=%h want %h", rd_data_way_o, exp_data);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    wr_en_i = 1; wr_way_i = 1; wr_index_i = 4; wr_word_i = 6; wr_be_i = 8'hFF; wr_data_i = 64'hDEAD;
    meta_we_i = 1; meta_way_i = 5; meta_index_i = 4; meta_tag_i = TW'(20'hBEEF5); meta_state_i = 2'd3;
    rd_req_i = 1; rd_index_i = 4; rd_word_i = 6;
    cycle(); set_idle();
    total++;
    if (rd_data_way_o[1*DW +: DW] !== 64'hDEAD) begin
      bad++; $display("FAIL bypass_data: got %h want dead", rd_data_way_o[1*DW +: DW]);
    end
    total++;
    if (rd_tag_way_o[5*TW +: TW] !== TW'(20'hBEEF5) || rd_state_way_o[11:10] !== 2'd3) begin
      bad++; $display("FAIL bypass_meta: tag=%h state=%0d want beef5/3", rd_tag_way_o[5*TW +: TW], rd_state_way_o[11:10]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_idle();
      rd_req_i = ($urandom_range(0, 3) != 0); rd_index_i = IW'($urandom_range(0, 3)); rd_word_i = KW'($urandom_range(0, 1));
      wr_en_i = $urandom_range(0, 1); wr_index_i = IW'($urandom_range(0, 3)); wr_word_i = KW'($urandom_range(0, 1));
      wr_way_i = WW'($urandom); wr_be_i = BW'($urandom); wr_data_i = {$urandom, $urandom};
      meta_we_i = ($urandom_range(0, 2) == 0); meta_index_i = IW'($urandom_range(0, 3));
      meta_way_i = WW'($urandom); meta_tag_i = TW'({$urandom, $urandom}); meta_state_i = 2'($urandom);
      cycle();
      total++;
      if (rd_valid_o !== exp_valid || rd_data_way_o !== exp_data || rd_tag_way_o !== exp_tag ||
          rd_state_way_o !== exp_state || rd_perr_way_o !== exp_perr) begin
        bad++;
        $display("FAIL random_%0d: valid=%b/%b state=%h/%h data=%h want %h", i, rd_valid_o, exp_valid,
                 rd_state_way_o, exp_state, rd_data_way_o, exp_data);
      end
    end
    set_idle();
  endtask

  task automatic test_walk();
    int busy_cnt, done_cnt;
    for (int i = 0; i < 2 * WAYS; i++) begin
      set_idle(); meta_we_i = 1; meta_index_i = (i < WAYS) ? IW'(0) : IW'(31); meta_way_i = WW'(i);
      meta_tag_i = TW'($urandom); meta_state_i = 2'($urandom_range(1, 3));
      cycle();
    end
    set_idle(); inv_all_i = 1; rd_req_i = 1; rd_index_i = 31; rd_word_i = 0;
    cycle(); set_idle();
    total++;
    if (rd_valid_o !== 1'b1 || rd_state_way_o !== exp_state || busy_o !== 1'b1) begin
      bad++; $display("FAIL walk_start: valid=%b busy=%b state=%h want 1/1/%h", rd_valid_o, busy_o, rd_state_way_o, exp_state);
    end
    busy_cnt = 1; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      if (busy_o) begin
        rd_req_i = 1; rd_index_i = ($urandom_range(0, 1) != 0) ? IW'(0) : IW'(31);
        wr_en_i = 1; wr_index_i = IW'(0); wr_way_i = WW'($urandom); wr_be_i = '1; wr_data_i = {$urandom, $urandom};
        meta_we_i = 1; meta_index_i = IW'(31); meta_way_i = WW'($urandom); meta_state_i = 2'd1;
        inv_all_i = $urandom_range(0, 1);
      end
      cycle();
      if (busy_o) busy_cnt++;
      if (inv_done_o) done_cnt++;
      total++;
      if (busy_o !== m_busy || inv_done_o !== m_done || rd_valid_o !== exp_valid) begin
        bad++; $display("FAIL walk_cycle_%0d: busy=%b/%b done=%b/%b valid=%b/%b", i, busy_o, m_busy,
                        inv_done_o, m_done, rd_valid_o, exp_valid);
      end
    end
    set_idle();
    total++;
    if (busy_cnt != SETS || done_cnt != 1) begin
      bad++; $display("FAIL walk_len: busy_cycles=%0d done_pulses=%0d want 32/1", busy_cnt, done_cnt);
    end
    for (int s = 0; s < SETS; s++) begin
      set_idle(); rd_req_i = 1; rd_index_i = IW'(s); rd_word_i = KW'(s % LW);
      cycle();
      total++;
      if (rd_valid_o !== 1'b1 || rd_state_way_o !== '0 || rd_data_way_o !== exp_data || rd_tag_way_o !== exp_tag) begin
        bad++; $display("FAIL walk_after_set%0d: valid=%b state=%h data=%h want %h", s, rd_valid_o,
                        rd_state_way_o, rd_data_way_o, exp_data);
      end
    end
    set_idle();
  endtask

  task automatic test_reset_walk();
    int done_cnt;
    for (int i = 0; i < 4; i++) begin
      set_idle(); meta_we_i = 1; meta_index_i = IW'(i * 9); meta_way_i = WW'(i); meta_tag_i = TW'(i); meta_state_i = 2'd2;
      cycle();
    end
    set_idle(); inv_all_i = 1;
    cycle(); set_idle();
    repeat (10) cycle();
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL rst_walk_busy: got %b want 1", busy_o); end
    #2 rst_ni = 0;
    #1 model_reset();
    total++;
    if (busy_o !== 1'b0 || inv_done_o !== 1'b0 || rd_valid_o !== 1'b0) begin
      bad++; $display("FAIL rst_walk_abort: busy=%b done=%b valid=%b want 000", busy_o, inv_done_o, rd_valid_o);
    end
    #1 rst_ni = 1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (inv_done_o || busy_o) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin bad++; $display("FAIL rst_walk_nodone: saw %0d busy/done cycles want 0", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      set_idle(); rd_req_i = 1; rd_index_i = IW'(i * 9); rd_word_i = KW'(i);
      cycle();
      total++;
      if (rd_valid_o !== 1'b1 || rd_state_way_o !== '0 || rd_data_way_o !== exp_data) begin
        bad++; $display("FAIL rst_walk_read%0d: valid=%b state=%h data=%h want %h", i, rd_valid_o,
                        rd_state_way_o, rd_data_way_o, exp_data);
      end
    end
    set_idle();
  endtask

  task automatic test_parity();
`ifdef L1_ARRAYS_PARITY_EN
    dut.r_data_mem[((9 * WAYS) + 2) * LW + 1] = dut.r_data_mem[((9 * WAYS) + 2) * LW + 1] ^ 64'h20;
    m_data[9][2][1] = m_data[9][2][1] ^ 64'h20;
    set_idle(); rd_req_i = 1; rd_index_i = 9; rd_word_i = 1;
    cycle(); set_idle();
    total++;
    if (rd_perr_way_o !== 8'h04 || rd_data_way_o !== exp_data) begin
      bad++; $display("FAIL parity_flip: perr=%h want 04", rd_perr_way_o);
    end
`else
    set_idle(); rd_req_i = 1; rd_index_i = 9; rd_word_i = 1;
    cycle(); set_idle();
    total++;
    if (rd_perr_way_o !== 8'h00 || rd_valid_o !== 1'b1) begin
      bad++; $display("FAIL parity_off: perr=%h valid=%b want 00/1", rd_perr_way_o, rd_valid_o);
    end
`endif
  endtask

  initial begin
    rst_ni = 0;
    set_idle();
    model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0;
        for (int k = 0; k < LW; k++) m_data[s][w][k] = '0;
      end
    #12 rst_ni = 1;
    @(posedge clk_i); #1;
    test_reset();
    fill_arrays();
    test_byte_write();
    test_bypass();
    test_random();
    test_walk();
    test_reset_walk();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
